// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word into IF/ID with stall, redirect and range faults.
module fetch_stage #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          IMEM_ADDR_BITS = 10,
   parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      redirect,
   input  logic [31:0]               redirect_target,
   output logic [IMEM_ADDR_BITS-1:0] imem_addr,
   input  logic [31:0]               imem_data,
   output logic [31:0]               pc,
   output logic [31:0]               ifid_instr,
   output logic [31:0]               ifid_pc_plus4,
   output logic                      ifid_valid,
   output logic                      ifid_fault,
   output logic [31:0]               fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [31:0] count_q, count_d;
   logic [31:0] pc_next;
   logic        out_of_range;

   assign pc_next      = pc_q + 32'd4;
   assign imem_addr    = pc_q[IMEM_ADDR_BITS+1:2];
   // Any set bit above the word index means the PC lies past the end of memory.
   assign out_of_range = (pc_q[31:IMEM_ADDR_BITS+2] != '0);

   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      count_d    = count_q;
      if (redirect) begin
         // Redirect beats stall; the word at the old PC is dropped as a bubble.
         pc_d       = {redirect_target[31:2], 2'b00};
         instr_d    = NOP_WORD;
         pc_plus4_d = 32'd0;
         valid_d    = 1'b0;
         fault_d    = 1'b0;
      end else if (!stall) begin
         pc_d       = pc_next;
         pc_plus4_d = pc_next;
         if (out_of_range) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b1;
         end else begin
            instr_d = imem_data;
            valid_d = 1'b1;
            fault_d = 1'b0;
            count_d = count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         instr_q    <= NOP_WORD;
         pc_plus4_q <= 32'd0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         count_q    <= 32'd0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         count_q    <= count_d;
      end
   end

   assign pc            = pc_q;
   assign ifid_instr    = instr_q;
   assign ifid_pc_plus4 = pc_plus4_q;
   assign ifid_valid    = valid_q;
   assign ifid_fault    = fault_q;
   assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural instruction memory feeds the
// stage and each step compares outputs against hand-computed values.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [9:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic        ifid_fault;
   logic [31:0] fetch_count;

   logic [31:0] mem [1024];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   fetch_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .pc              (pc),
      .ifid_instr      (ifid_instr),
      .ifid_pc_plus4   (ifid_pc_plus4),
      .ifid_valid      (ifid_valid),
      .ifid_fault      (ifid_fault),
      .fetch_count     (fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_p4, input logic e_valid, input logic e_fault,
                           input logic [31:0] e_count);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".instr"}, ifid_instr, e_instr);
      chk({tag, ".pc_plus4"}, ifid_pc_plus4, e_p4);
      chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
      chk({tag, ".fault"}, {31'd0, ifid_fault}, {31'd0, e_fault});
      chk({tag, ".count"}, fetch_count, e_count);
   endtask

   // Advance one clock and settle just after the edge, then drive new inputs.
   task automatic step(input logic s, input logic r, input logic [31:0] tgt);
      stall = s;
      redirect = r;
      redirect_target = tgt;
      @(posedge clk);
      #1;
      stall = 1'b0;
      redirect = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

      #12;
      chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      chk("reset.imem_addr", {22'd0, imem_addr}, 32'd0);
      reset = 1'b0;
      #1;

      // Sequential fetch of words 0 and 1.
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("adv1", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 32'd1);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("adv2", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 32'd2);

      // Three stalled edges at pc=8 hold everything.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0);
         chk_ifid("stall", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 32'd2);
      end
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("adv3", 32'hC, 32'h33, 32'hC, 1'b1, 1'b0, 32'd3);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("adv4", 32'h10, 32'h44, 32'h10, 1'b1, 1'b0, 32'd4);

      // Return to 0, fetch once so pc=4 with a valid word in IF/ID.
      step(1'b0, 1'b1, 32'h0);
      chk_ifid("redir0", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("adv5", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 32'd5);

      // Unaligned target is forced to a word boundary and IF/ID is flushed.
      step(1'b0, 1'b1, 32'h0000_0013);
      chk_ifid("redir13", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("adv6", 32'h14, 32'hC0DE_0004, 32'h14, 1'b1, 1'b0, 32'd6);

      // Stall and redirect together: redirect wins.
      step(1'b1, 1'b1, 32'h20);
      chk_ifid("stall_redir", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);

      // Last memory word, then the first out-of-range PC.
      step(1'b0, 1'b1, 32'hFFC);
      chk("ffc.imem_addr", {22'd0, imem_addr}, 32'd1023);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("last_word", 32'h1000, 32'hC0DE_03FF, 32'h1000, 1'b1, 1'b0, 32'd7);
      chk("oor.imem_addr", {22'd0, imem_addr}, 32'd0);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("fault", 32'h1004, 32'h0, 32'h1004, 1'b0, 1'b1, 32'd7);

      // A stalled faulting state holds the fault flag.
      step(1'b1, 1'b0, 32'h0);
      chk_ifid("fault_hold", 32'h1004, 32'h0, 32'h1004, 1'b0, 1'b1, 32'd7);

      // PC wraps from the top of the address space to zero.
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      chk_ifid("redir_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd7);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("wrap", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd7);

      // Reach pc=0x40 with a valid word, then reset between edges mid-stall.
      step(1'b0, 1'b1, 32'h3C);
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("pre_reset", 32'h40, 32'hC0DE_000F, 32'h40, 1'b1, 1'b0, 32'd8);
      stall = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk_ifid("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      stall = 1'b0;
      step(1'b0, 1'b0, 32'h0);
      chk_ifid("resume", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory. Holds the program counter, drives the memory's 10-bit word address, and captures the returned 32-bit word into the IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect with bubble insertion, and out-of-range fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
IMEM_ADDR_BITS, 10, width of instruction-memory word address (1024 words)
NOP_WORD, 32'h0000_0000, instruction word inserted for bubbles and faults

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID register this cycle
redirect  in  1  branch/jump taken; load redirect_target, flush IF/ID
redirect_target  in  32  byte address of redirect destination
imem_addr  out  IMEM_ADDR_BITS  word address to instruction memory (combinational from PC)
imem_data  in  32  instruction word from memory (combinational read, same cycle)
pc  out  32  current fetch PC (byte address)
ifid_instr  out  32  registered instruction for decode
ifid_pc_plus4  out  32  registered PC+4 of that instruction
ifid_valid  out  1  ifid_instr is a real fetched instruction
ifid_fault  out  1  ifid_instr came from an out-of-range PC
fetch_count  out  32  number of valid instructions delivered to IF/ID

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0, ifid_fault=0, fetch_count=0. Outputs change immediately on reset assertion, without waiting for a clock edge.
- imem_addr = pc[IMEM_ADDR_BITS+1:2]; purely combinational; pc[1:0] always 00.
- out_of_range = (pc[31:IMEM_ADDR_BITS+2] != 0), combinational.
- Priority at each rising edge: redirect > stall > advance.
- Advance (stall=0, redirect=0): pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0); ifid_pc_plus4<=pc+4; if out_of_range: ifid_instr<=NOP_WORD, ifid_valid<=0, ifid_fault<=1; else ifid_instr<=imem_data, ifid_valid<=1, ifid_fault<=0, fetch_count<=fetch_count+1.
- Stall (stall=1, redirect=0): pc, IF/ID register and fetch_count all hold.
- Redirect (redirect=1, stall ignored): pc<={redirect_target[31:2],2'b00}; IF/ID <= bubble (ifid_instr=NOP_WORD, ifid_valid=0, ifid_fault=0, ifid_pc_plus4=0); fetch_count holds. The word at the old pc is discarded.
- Latency: instruction at PC p appears on ifid_* one edge after pc=p with no stall/redirect. The first valid instruction appears at the first edge after reset deasserts.
- Word index wraps naturally: pc=0xFFC -> imem_addr=1023; next pc=0x1000 is out_of_range.
- fetch_count wraps at 2^32 (modulo).
- No internal state machine beyond the PC/IF-ID registers. Redirect and stall are level-sampled at each edge only.

Test Plan:
1. Reset, memory words 0..3 = 0x11,0x22,0x33,0x44, no stall -> edges 1..4 give ifid_instr 0x11..0x44, ifid_pc_plus4 4,8,12,16, ifid_valid=1, fetch_count=4.
2. At pc=8, assert stall for 3 cycles -> pc stays 8, ifid holds 0x22/pc_plus4=8; after release, next edge gives 0x33.
3. At pc=4, redirect=1 with target 0x0000_0013 -> next edge: pc=0x10, ifid_valid=0, ifid_instr=0; following edge: ifid_instr=mem[4], pc_plus4=0x14.
4. stall=1 and redirect=1 with target 0x20 in the same cycle -> redirect wins: pc=0x20, bubble in IF/ID.
5. Redirect to 0xFFC, then advance twice -> first edge: ifid_instr=mem[1023], valid=1; second edge (pc=0x1000): ifid_fault=1, valid=0, instr=NOP, fetch_count unchanged.
6. Assert reset between clock edges while pc=0x40 -> pc=0 and ifid_valid=0 immediately; fetch resumes from word 0 after release.
